// File: rtl/pid_mul_seq.sv
// Sequential signed shift-add multiplier for the PID gain products.
// Latency WIDTH+2 edges from accept to o_valid; i_start is ignored while o_busy is high.
module pid_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       hi_sum;
  logic [2*WIDTH:0]     acc_add;
  logic [2*WIDTH-1:0]   mag;

  // Upper half of the accumulator plus the multiplicand; one adder reused every iteration.
  assign hi_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
  assign acc_add = mplier_q[0] ? {hi_sum, acc_q[WIDTH-1:0]} : acc_q;
  assign mag     = acc_q[2*WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    p_d      = p_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
          mcand_d  = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
          mplier_d = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
          neg_d    = i_a[WIDTH-1] ^ i_b[WIDTH-1];
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_add >> 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        p_d     = neg_q ? (~mag + 1'b1) : mag;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_p     = p_q;

endmodule
